// File: rtl/dmem_ctrl_if.sv
// Data-memory bus between the dmem_ctrl master and a memory/bus slave.
// Handshake: the master raises bus_req_o with bus_we_o, bus_addr_o,
// bus_wdata_o and bus_be_o and holds all of them stable until the slave
// answers with bus_gnt_i in the same cycle (request accepted on the rising
// edge where bus_req_o && bus_gnt_i). For loads, the slave later returns
// bus_rdata_i qualified by a single-cycle bus_rvalid_i; the master always
// accepts it (no back-pressure on the response).
interface dmem_ctrl_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM stage: turns a load/store request into
// one bus transaction, stalling the pipeline until it completes.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses (adds misalign_o / badaddr_o, no bus request for such accesses).
module dmem_ctrl (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        re_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  mode_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_o,
    output logic [31:0] badaddr_o,
`endif
    output logic [1:0]  state_o,
    dmem_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t      state_q, state_d;
    logic        capture;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic [31:0] rdata_q;
    logic [3:0]  be_w;
    logic [31:0] wdata_w;

    // funct3[2] only selects sign/zero extension, which is applied downstream.
    logic unused_mode;
    assign unused_mode = mode_i[2];

`ifdef MISALIGN_TRAP_EN
    logic mis_req;
    logic mis_q;

    // Halfword needs addr[0]==0, word (and the reserved size) needs addr[1:0]==0.
    always_comb begin
        mis_req = 1'b0;
        if (mode_i[1])
            mis_req = (addr_i[1:0] != 2'b00);
        else if (mode_i[0])
            mis_req = addr_i[0];
    end
`endif

    // State register; reset returns to IDLE at once, dropping any open transaction.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; stray grants/responses are ignored outside REQ/WAIT.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (re_i || we_i) begin
                    capture = 1'b1;
`ifdef MISALIGN_TRAP_EN
                    state_d = mis_req ? DONE : REQ;
`else
                    state_d = REQ;
`endif
                end
            end
            REQ:     if (bus.bus_gnt_i) state_d = we_q ? DONE : WAIT;
            WAIT:    if (bus.bus_rvalid_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture in IDLE; store wins when both requests are high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
        end else if (capture) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            size_q  <= mode_i[1:0];
            we_q    <= we_i;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Misalignment flag for the access currently in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            mis_q <= 1'b0;
        else if (capture)
            mis_q <= mis_req;
    end
`endif

    // Load data: right-align the addressed bytes; held until the next load returns.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            rdata_q <= '0;
        else if (state_q == WAIT && bus.bus_rvalid_i)
            rdata_q <= bus.bus_rdata_i >> {addr_q[1:0], 3'b000};
    end

    // Byte lanes and replicated store data derived from access size and offset.
    always_comb begin
        be_w    = 4'b1111;
        wdata_w = wdata_q;
        case (size_q)
            2'b00: begin
                be_w    = 4'b0001 << addr_q[1:0];
                wdata_w = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_w    = 4'b0011 << {addr_q[1], 1'b0};
                wdata_w = {2{wdata_q[15:0]}};
            end
            default: begin
                be_w    = 4'b1111;
                wdata_w = wdata_q;
            end
        endcase
    end

    // Outputs; bus fields are driven only while requesting so they read 0 otherwise.
    always_comb begin
        stall_o         = 1'b0;
        done_o          = 1'b0;
        bus.bus_req_o   = 1'b0;
        bus.bus_we_o    = 1'b0;
        bus.bus_addr_o  = '0;
        bus.bus_wdata_o = '0;
        bus.bus_be_o    = '0;
        case (state_q)
            IDLE: stall_o = re_i || we_i;
            REQ: begin
                stall_o         = 1'b1;
                bus.bus_req_o   = 1'b1;
                bus.bus_we_o    = we_q;
                bus.bus_addr_o  = {addr_q[31:2], 2'b00};
                bus.bus_wdata_o = wdata_w;
                bus.bus_be_o    = be_w;
            end
            WAIT:    stall_o = 1'b1;
            DONE:    done_o  = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    assign rdata_o = rdata_q;
    assign state_o = state_q;

`ifdef MISALIGN_TRAP_EN
    assign misalign_o = (state_q == DONE) && mis_q;
    assign badaddr_o  = misalign_o ? addr_q : 32'd0;
`endif

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have port clk_i  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port re_i  in  1  load request from MEM stage.
REQ-004 SHALL have port we_i  in  1  store request from MEM stage.
REQ-005 SHALL have port addr_i  in  32  byte address (ALU result).
REQ-006 SHALL have port wdata_i  in  32  store data (rs2 value).
REQ-007 SHALL have port mode_i  in  3  funct3 of the load/store.
REQ-008 SHALL have port stall_o  out  1  hold the pipeline while high.
REQ-009 SHALL have port rdata_o  out  32  loaded bytes, right-aligned, not extended.
REQ-010 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports bus_req_o, bus_we_o  out  1 each  bus request and direction.
REQ-012 SHALL have ports bus_addr_o, bus_wdata_o  out  32 each, and bus_be_o  out  4  (byte enables).
REQ-013 SHALL have ports bus_gnt_i, bus_rvalid_i  in  1 each, and bus_rdata_i  in  32.

Function
REQ-014 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-015 IDLE: re_i or we_i high -> capture addr/wdata/mode/direction and go to REQ; we_i wins if both are high.
REQ-016 stall_o SHALL be high when (IDLE and (re_i or we_i)), or in REQ or WAIT; it SHALL be low in DONE.
REQ-017 REQ: bus_req_o held high with stable address, data and byte enables until bus_gnt_i; a granted store goes to DONE, a granted load goes to WAIT.
REQ-018 WAIT: on bus_rvalid_i, register bus_rdata_i >> (8*addr[1:0]) into rdata_o, then go to DONE.
REQ-019 DONE: done_o=1 for exactly one cycle, then go to IDLE unconditionally; rdata_o holds until the next load completes.
REQ-020 bus_addr_o SHALL be {addr[31:2],2'b00}.
REQ-021 Byte enables: SB = 0001<<addr[1:0]; SH = 0011<<{addr[1],1'b0}; SW = 1111.
REQ-022 Store data: SB replicates the byte 4x; SH replicates the halfword 2x; SW passes the word through.
REQ-023 bus_gnt_i outside REQ and bus_rvalid_i outside WAIT SHALL be ignored.
REQ-024 Minimum load latency: request cycle plus REQ plus WAIT gives 3 stall cycles, with DONE in cycle 4. Minimum store latency is 2 stall cycles.

Reset
REQ-025 Reset assertion SHALL force IDLE immediately, including mid-transaction.
REQ-026 On reset all outputs SHALL be 0.
REQ-027 A bus response arriving after reset SHALL be discarded.

Configuration
REQ-028 With MISALIGN_TRAP_EN defined, the block SHALL add outputs misalign_o (1) and badaddr_o (32).
REQ-029 With MISALIGN_TRAP_EN, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL go IDLE->DONE without a bus request. In that DONE cycle misalign_o=1 and badaddr_o=addr_i, with 1 stall cycle. Both outputs reset to 0.
REQ-030 Without MISALIGN_TRAP_EN, the ports are absent and misaligned low address bits are ignored per REQ-021.

Verification
REQ-031 LW 0x100, gnt in the first REQ cycle, rvalid next cycle with 0xDEADBEEF -> stall 3 cycles, done_o in cycle 4, rdata_o=0xDEADBEEF.
REQ-032 SB 0x103, wdata 0x000000A5 -> bus_be_o=1000, bus_wdata_o=0xA5A5A5A5, bus_addr_o=0x100.
REQ-033 LHU 0x202, bus_rdata 0x1234ABCD -> rdata_o=0x00001234.
REQ-034 gnt withheld for 5 cycles -> bus_req_o and all bus outputs stable for all 5 cycles, stall_o high throughout.
REQ-035 rst_n_i pulsed low while in WAIT, then rvalid -> IDLE, all outputs 0, response ignored, no done_o pulse.
REQ-036 With MISALIGN_TRAP_EN, LW 0x101 -> no bus_req_o, misalign_o=1, badaddr_o=0x101, 1 stall cycle.
